pmci_egrs_spis_avmm: RTL and testbench
======================================

# pmci_egrs_spis_avmm

SPI slave that terminates the BMC-side egress SPI master link on the FPGA side of the PMCI MCTP path. It decodes framed write/read commands on SPI mode 0 and converts them into single-word AVMM master transactions toward the PCIe VDM egress buffer. It is the responder counterpart to the BMC's egress AVMM-to-SPI-master bridge, and it completes the loopback pair in the tb_pmci_mctp environment.

## Interface
- `SYNC_DEPTH`, 2: synchronizer flops on `spis_clk`, `spis_csn` and `spis_mosi`.
- `ADDR_WIDTH`, 16: AVMM word-address width; must be 16 or less.
- `MAX_BURST`, 64: maximum words per frame. A larger length field is a frame error.

Ports:
- `clk`, in, 1: system clock. All logic runs on this clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `spis_clk`, in, 1: SPI SCLK, asynchronous to `clk`.
- `spis_csn`, in, 1: chip select, active low.
- `spis_mosi`, in, 1: serial data in, MSB first.
- `spis_miso`, out, 1: serial data out, MSB first.
- `avmm_addr`, out, ADDR_WIDTH: word address.
- `avmm_write`, out, 1: write request.
- `avmm_read`, out, 1: read request.
- `avmm_wrdata`, out, 32: write data.
- `avmm_byteen`, out, 4: byte enables, always 4'hF.
- `avmm_rddata`, in, 32: read data.
- `avmm_rddvld`, in, 1: read data valid.
- `avmm_waitreq`, in, 1: wait request.
- `frame_done`, out, 1: one-cycle pulse when a frame finishes without error.
- `frame_err`, out, 1: one-cycle pulse on any frame error.

## Operation
- SPI mode 0.
  - Sample MOSI on synchronized SCLK rising edges.
  - Update MISO on synchronized SCLK falling edges.
  - SCLK high and low phases are each at least 4 `clk` periods.
- Frame layout, all fields sent while CSN is low:
  - CMD byte: 0x02 = write, 0x03 = read. Any other value sets ERR.
  - ADDR: 16 bits. Bits above ADDR_WIDTH are ignored.
  - LEN byte: N, giving N words. N=0 or N>MAX_BURST sets ERR.
  - Payload: N × 32-bit words.
- Write frame:
  - When each 32-bit word is fully received, assert `avmm_write` with `avmm_addr` = ADDR+i.
  - Hold the request until `avmm_waitreq`=0.
- Read frame:
  - Issue `avmm_read` for word 0 immediately after LEN.
  - Master clocks 8 dummy bits, then N words are shifted out on MISO.
  - Read for word i+1 is issued when shifting of word i begins.
  - Data is captured on `avmm_rddvld`.
  - If `avmm_rddvld` for a word has not arrived when its first bit must be driven, shift 0xFFFFFFFF for that word and set ERR.
- State machine:
  - IDLE →(CSN fall) CMD → ADDR → LEN → WDATA or RDUMMY.
  - RDUMMY → RDATA.
  - WDATA / RDATA →(N words done) DONE.
  - Any state →(error) ERR.
  - ERR ignores all bits until CSN rises.
- CSN rise:
  - From DONE: pulse `frame_done`, go to IDLE.
  - From any other non-IDLE state: abort and go to IDLE.
  - Abort is a frame error. In ERR, `frame_err` pulses on error entry, exactly once per frame.
- A pending AVMM request (waitreq held high) is never dropped by CSN rise or an error. It completes before its `avmm_write`/`avmm_read` deasserts.
- Write overrun: if word i+1 completes while write i is still held off by waitreq, the new word is discarded and ERR is set.
- Address arithmetic: ADDR+i wraps modulo 2^ADDR_WIDTH.
- Extra SCLK edges after the last word in DONE are ignored.
- `spis_miso` is 0 whenever CSN is high, and in the CMD, ADDR and LEN states.

## Timing
- Reset values:
  - `spis_miso`, `avmm_write`, `avmm_read`, `frame_done`, `frame_err` = 0.
  - `avmm_addr`, `avmm_wrdata` = 0.
  - `avmm_byteen` = 4'hF.
  - FSM = IDLE.
- Reset mid-frame returns everything to the reset state on the next `clk`, including any held AVMM request. The remainder of that frame is ignored until CSN rises and falls again.
- Input path latency: SYNC_DEPTH + 1 `clk` cycles from a pin change to the edge being detected.
- Write request: `avmm_write` asserts 1 cycle after detection of the 32nd data bit of the word, then holds while waitreq=1.
- Read request: `avmm_read` asserts 1 cycle after LEN completes (word 0) or after the first falling edge of word i (word i+1).
- `frame_done` / `frame_err` pulse 1 cycle after the synchronized event is detected.

## Test plan
- Write frame 02 0010 02 11223344 AABBCCDD, waitreq=0 → writes addr 0x0010 = 0x11223344, addr 0x0011 = 0xAABBCCDD; `frame_done`=1.
- Read frame 03 0020 03, memory model with 2-cycle rddvld latency → MISO returns 3 words matching addr 0x20..0x22; `frame_done`=1; no `frame_err`.
- Write of 2 words with waitreq held high for 400 cycles on word 0 → overrun, second word dropped, one `frame_err`; word 0 still written once.
- CMD 0x7E, and separately LEN=0 → no AVMM activity; `frame_err` pulses once per frame; next valid frame is accepted.
- CSN rises after 12 ADDR bits; then ADDR 0xFFFF with LEN=2 → first frame gives `frame_err` and no write; second frame writes 0xFFFF then 0x0000.
- `reset_n` low for 1 cycle during word 1 of a 4-word write → all outputs at reset values; no further writes for that frame; the following frame succeeds.

Source files
------------

// File: rtl/pmci_egrs_spis_avmm.sv
// SPI mode-0 slave for the PMCI egress link: decodes framed write/read commands
// and turns them into single-word AVMM master transactions.
//   state  | meaning
//   IDLE   | waiting for CSN fall
//   CMD    | shifting command byte
//   ADDR   | shifting 16-bit word address
//   LEN    | shifting word count
//   WDATA  | receiving write words, issuing avmm_write per word
//   RDUMMY | 8 turnaround bits while word 0 is fetched
//   RDATA  | shifting read words out on MISO
//   DONE   | all words transferred, waiting for CSN rise
//   ERR    | frame error, ignoring bits until CSN rise
module pmci_egrs_spis_avmm #(
  parameter int SYNC_DEPTH = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spis_clk,
  input  logic                  spis_csn,
  input  logic                  spis_mosi,
  output logic                  spis_miso,
  output logic [ADDR_WIDTH-1:0] avmm_addr,
  output logic                  avmm_write,
  output logic                  avmm_read,
  output logic [31:0]           avmm_wrdata,
  output logic [3:0]            avmm_byteen,
  input  logic [31:0]           avmm_rddata,
  input  logic                  avmm_rddvld,
  input  logic                  avmm_waitreq,
  output logic                  frame_done,
  output logic                  frame_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_WDATA, S_RDUMMY, S_RDATA, S_DONE, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_DEPTH-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_DEPTH-1:0]   csn_sync_q, csn_sync_d;
  logic [SYNC_DEPTH-1:0]   mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d, csn_prev_q, csn_prev_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [30:0]             sh_in_q, sh_in_d;
  logic [31:0]             sh_out_q, sh_out_d;
  logic                    cmd_rd_q, cmd_rd_d;
  logic [ADDR_WIDTH-1:0]   addr_base_q, addr_base_d;
  logic [7:0]              len_q, len_d, word_idx_q, word_idx_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    miso_q, miso_d;
  logic                    avmm_write_q, avmm_write_d, avmm_read_q, avmm_read_d;
  logic [ADDR_WIDTH-1:0]   avmm_addr_q, avmm_addr_d;
  logic [31:0]             avmm_wrdata_q, avmm_wrdata_d;
  logic                    done_q, done_d, err_q, err_d;

  logic                    sclk_s, csn_s, mosi_s;
  logic                    sclk_rise, sclk_fall, csn_rise, csn_fall, tc;
  logic [31:0]             sh_next;
  logic                    word_last, go_err, rd_issue;
  logic [ADDR_WIDTH-1:0]   word_addr, rd_issue_addr;

  assign sclk_s    = sclk_sync_q[SYNC_DEPTH-1];
  assign csn_s     = csn_sync_q[SYNC_DEPTH-1];
  assign mosi_s    = mosi_sync_q[SYNC_DEPTH-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign tc        = sclk_rise && (bit_cnt_q == 5'd0);
  assign sh_next   = {sh_in_q, mosi_s};
  assign word_last = (word_idx_q + 8'd1) == len_q;
  assign word_addr = addr_base_q + ADDR_WIDTH'(word_idx_q);

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_DEPTH-2:0], spis_clk};
    csn_sync_d    = {csn_sync_q[SYNC_DEPTH-2:0], spis_csn};
    mosi_sync_d   = {mosi_sync_q[SYNC_DEPTH-2:0], spis_mosi};
    sclk_prev_d   = sclk_s;
    csn_prev_d    = csn_s;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    sh_in_d       = sh_in_q;
    sh_out_d      = sh_out_q;
    cmd_rd_d      = cmd_rd_q;
    addr_base_d   = addr_base_q;
    len_d         = len_q;
    word_idx_d    = word_idx_q;
    rd_data_d     = rd_data_q;
    rd_vld_d      = rd_vld_q;
    miso_d        = miso_q;
    avmm_write_d  = avmm_write_q & avmm_waitreq;
    avmm_read_d   = avmm_read_q & avmm_waitreq;
    avmm_addr_d   = avmm_addr_q;
    avmm_wrdata_d = avmm_wrdata_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    go_err        = 1'b0;
    rd_issue      = 1'b0;
    rd_issue_addr = addr_base_q;

    if (avmm_rddvld) begin
      rd_data_d = avmm_rddata;
      rd_vld_d  = 1'b1;
    end

    if (csn_rise) begin
      miso_d  = 1'b0;
      state_d = S_IDLE;
      if (state_q == S_DONE) done_d = 1'b1;
      else if (state_q != S_IDLE && state_q != S_ERR) err_d = 1'b1;
    end else if (csn_fall && state_q == S_IDLE) begin
      state_d    = S_CMD;
      bit_cnt_d  = 5'd7;
      word_idx_d = 8'd0;
      miso_d     = 1'b0;
    end else if (!csn_s) begin
      // bit counter is a down-counter; it wraps 0 -> 31 for back-to-back data words
      if (sclk_rise) begin
        sh_in_d   = sh_next[30:0];
        bit_cnt_d = bit_cnt_q - 5'd1;
      end
      case (state_q)
        S_CMD: if (tc) begin
          if (sh_next[7:0] == 8'h02 || sh_next[7:0] == 8'h03) begin
            cmd_rd_d  = sh_next[0];
            state_d   = S_ADDR;
            bit_cnt_d = 5'd15;
          end else go_err = 1'b1;
        end
        S_ADDR: if (tc) begin
          addr_base_d = sh_next[ADDR_WIDTH-1:0];
          state_d     = S_LEN;
          bit_cnt_d   = 5'd7;
        end
        S_LEN: if (tc) begin
          if (sh_next[7:0] == 8'd0 || int'(sh_next[7:0]) > MAX_BURST) go_err = 1'b1;
          else begin
            len_d      = sh_next[7:0];
            word_idx_d = 8'd0;
            if (cmd_rd_q) begin
              state_d   = S_RDUMMY;
              bit_cnt_d = 5'd7;
              rd_issue  = 1'b1;
            end else begin
              state_d   = S_WDATA;
              bit_cnt_d = 5'd31;
            end
          end
        end
        S_WDATA: if (tc) begin
          if (avmm_write_q && avmm_waitreq) go_err = 1'b1;
          else begin
            avmm_write_d  = 1'b1;
            avmm_addr_d   = word_addr;
            avmm_wrdata_d = sh_next;
            if (word_last) state_d = S_DONE;
            else word_idx_d = word_idx_q + 8'd1;
          end
        end
        S_RDUMMY: if (tc) begin
          state_d   = S_RDATA;
          bit_cnt_d = 5'd31;
        end
        S_RDATA: begin
          if (sclk_fall && bit_cnt_q == 5'd31) begin
            // first bit of a word: the fetched data must already be here
            if (rd_vld_q) begin
              miso_d   = rd_data_q[31];
              sh_out_d = {rd_data_q[30:0], 1'b0};
              rd_vld_d = 1'b0;
              if (!word_last) begin
                rd_issue      = 1'b1;
                rd_issue_addr = word_addr + ADDR_WIDTH'(1);
              end
            end else begin
              miso_d = 1'b1;
              go_err = 1'b1;
            end
          end else if (sclk_fall) begin
            miso_d   = sh_out_q[31];
            sh_out_d = {sh_out_q[30:0], 1'b0};
          end else if (tc) begin
            if (word_last) state_d = S_DONE;
            else word_idx_d = word_idx_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    if (go_err) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end
    if (rd_issue && !(avmm_read_q && avmm_waitreq)) begin
      avmm_read_d = 1'b1;
      avmm_addr_d = rd_issue_addr;
      rd_vld_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      sclk_sync_q   <= '0;
      csn_sync_q    <= '0;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      csn_prev_q    <= 1'b0;
      bit_cnt_q     <= 5'd0;
      sh_in_q       <= '0;
      sh_out_q      <= '0;
      cmd_rd_q      <= 1'b0;
      addr_base_q   <= '0;
      len_q         <= 8'd0;
      word_idx_q    <= 8'd0;
      rd_data_q     <= '0;
      rd_vld_q      <= 1'b0;
      miso_q        <= 1'b0;
      avmm_write_q  <= 1'b0;
      avmm_read_q   <= 1'b0;
      avmm_addr_q   <= '0;
      avmm_wrdata_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      csn_sync_q    <= csn_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      csn_prev_q    <= csn_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      sh_in_q       <= sh_in_d;
      sh_out_q      <= sh_out_d;
      cmd_rd_q      <= cmd_rd_d;
      addr_base_q   <= addr_base_d;
      len_q         <= len_d;
      word_idx_q    <= word_idx_d;
      rd_data_q     <= rd_data_d;
      rd_vld_q      <= rd_vld_d;
      miso_q        <= miso_d;
      avmm_write_q  <= avmm_write_d;
      avmm_read_q   <= avmm_read_d;
      avmm_addr_q   <= avmm_addr_d;
      avmm_wrdata_q <= avmm_wrdata_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign spis_miso   = miso_q;
  assign avmm_addr   = avmm_addr_q;
  assign avmm_write  = avmm_write_q;
  assign avmm_read   = avmm_read_q;
  assign avmm_wrdata = avmm_wrdata_q;
  assign avmm_byteen = 4'hF;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_pmci_egrs_spis_avmm.sv
// Bench for pmci_egrs_spis_avmm: SPI master stimulus, AVMM memory responder,
// and scoreboards for expected writes and expected MISO read words.
`timescale 1ns/1ps
module tb_pmci_egrs_spis_avmm;
  localparam int HALF = 5;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spis_clk = 1'b0, spis_csn = 1'b1, spis_mosi = 1'b0;
  logic        spis_miso;
  logic [15:0] avmm_addr;
  logic        avmm_write, avmm_read;
  logic [31:0] avmm_wrdata;
  logic [3:0]  avmm_byteen;
  logic [31:0] avmm_rddata = '0;
  logic        avmm_rddvld = 1'b0, avmm_waitreq = 1'b0;
  logic        frame_done, frame_err;

  always #5 clk = ~clk;

  pmci_egrs_spis_avmm dut (
    .clk(clk), .reset_n(reset_n),
    .spis_clk(spis_clk), .spis_csn(spis_csn), .spis_mosi(spis_mosi), .spis_miso(spis_miso),
    .avmm_addr(avmm_addr), .avmm_write(avmm_write), .avmm_read(avmm_read),
    .avmm_wrdata(avmm_wrdata), .avmm_byteen(avmm_byteen),
    .avmm_rddata(avmm_rddata), .avmm_rddvld(avmm_rddvld), .avmm_waitreq(avmm_waitreq),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  int n_cmp = 0, n_bad = 0;
  int n_wr = 0, n_rd = 0, n_done = 0, n_ferr = 0;
  int wr_hold = 0;
  int d0, e0, w0, r0;
  logic [47:0] wr_exp_q[$];
  logic [31:0] rd_exp_q[$];
  logic        pipe_v [2];
  logic [31:0] pipe_d [2];
  logic [7:0]  bad_cmd [3] = '{8'h7E, 8'h02, 8'h02};
  logic [7:0]  bad_len [3] = '{8'h01, 8'h00, 8'h41};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  // AVMM responder: waitreq decided first, then acceptance for the coming posedge
  always @(negedge clk) begin
    logic [47:0] e;
    avmm_rddvld = pipe_v[1];
    avmm_rddata = pipe_d[1];
    pipe_v[1] = pipe_v[0];
    pipe_d[1] = pipe_d[0];
    pipe_v[0] = 1'b0;
    if ((avmm_write || avmm_read) && wr_hold > 0) begin
      avmm_waitreq = 1'b1;
      wr_hold--;
    end else avmm_waitreq = 1'b0;
    if (reset_n && avmm_write && !avmm_waitreq) begin
      n_wr++;
      if (wr_exp_q.size() == 0) chk("wr_unexpected", 64'(wr_exp_q.size()), 64'(1));
      else begin
        e = wr_exp_q.pop_front();
        chk("wr_addr", 64'(avmm_addr), 64'(e[47:32]));
        chk("wr_data", 64'(avmm_wrdata), 64'(e[31:0]));
      end
    end
    if (reset_n && avmm_read && !avmm_waitreq) begin
      n_rd++;
      pipe_v[0] = 1'b1;
      pipe_d[0] = memf(avmm_addr);
    end
    n_done += int'(frame_done);
    n_ferr += int'(frame_err);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spis_mosi = tx[i];
      wait_clk(HALF);
      spis_clk = 1'b1;
      rx = {rx[30:0], spis_miso};
      wait_clk(HALF);
      spis_clk = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] len);
    logic [31:0] rx;
    spi_xfer({24'h0, cmd}, 8, rx);
    spi_xfer({16'h0, addr}, 16, rx);
    spi_xfer({24'h0, len}, 8, rx);
  endtask

  task automatic csn_low;
    spis_csn = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic csn_high;
    wait_clk(HALF);
    spis_csn = 1'b1;
    wait_clk(12);
  endtask

  task automatic snap;
    d0 = n_done; e0 = n_ferr; w0 = n_wr; r0 = n_rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
    pipe_d[0] = '0;   pipe_d[1] = '0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    chk("rst_miso",   64'(spis_miso),   64'(0));
    chk("rst_write",  64'(avmm_write),  64'(0));
    chk("rst_read",   64'(avmm_read),   64'(0));
    chk("rst_addr",   64'(avmm_addr),   64'(0));
    chk("rst_wrdata", 64'(avmm_wrdata), 64'(0));
    chk("rst_byteen", 64'(avmm_byteen), 64'(4'hF));
    chk("rst_done",   64'(frame_done),  64'(0));
    chk("rst_err",    64'(frame_err),   64'(0));

    // two-word write, no wait states
    snap();
    wr_exp_q.push_back({16'h0010, 32'h11223344});
    wr_exp_q.push_back({16'h0011, 32'hAABBCCDD});
    csn_low();
    send_hdr(8'h02, 16'h0010, 8'h02);
    spi_xfer(32'h11223344, 32, rx);
    spi_xfer(32'hAABBCCDD, 32, rx);
    csn_high();
    chk("wr2_left", 64'(wr_exp_q.size()), 64'(0));
    chk("wr2_done", 64'(n_done - d0), 64'(1));
    chk("wr2_err",  64'(n_ferr - e0), 64'(0));

    // three-word read, memory answers two cycles after acceptance
    snap();
    for (int i = 0; i < 3; i++) rd_exp_q.push_back(memf(16'h0020 + 16'(i)));
    csn_low();
    send_hdr(8'h03, 16'h0020, 8'h03);
    spi_xfer(32'h0, 8, rx);
    for (int i = 0; i < 3; i++) begin
      spi_xfer(32'h0, 32, rx);
      if (rd_exp_q.size() == 0) chk("rd_unexpected", 64'(rd_exp_q.size()), 64'(1));
      else chk("rd_word", 64'(rx), 64'(rd_exp_q.pop_front()));
    end
    csn_high();
    chk("rd_done",  64'(n_done - d0), 64'(1));
    chk("rd_err",   64'(n_ferr - e0), 64'(0));
    chk("rd_count", 64'(n_rd - r0),   64'(3));
    chk("miso_csn_high", 64'(spis_miso), 64'(0));

    // overrun: word 0 held off by waitreq while word 1 arrives
    snap();
    wr_hold = 400;
    wr_exp_q.push_back({16'h0030, 32'hCAFE0001});
    csn_low();
    send_hdr(8'h02, 16'h0030, 8'h02);
    spi_xfer(32'hCAFE0001, 32, rx);
    spi_xfer(32'hCAFE0002, 32, rx);
    csn_high();
    wait_clk(300);
    chk("ovr_left",  64'(wr_exp_q.size()), 64'(0));
    chk("ovr_wrs",   64'(n_wr - w0),       64'(1));
    chk("ovr_err",   64'(n_ferr - e0),     64'(1));
    chk("ovr_done",  64'(n_done - d0),     64'(0));

    // bad command, LEN=0, LEN=MAX_BURST+1
    for (int i = 0; i < 3; i++) begin
      snap();
      csn_low();
      send_hdr(bad_cmd[i], 16'h0040, bad_len[i]);
      spi_xfer(32'h12345678, 32, rx);
      csn_high();
      chk("bad_err",  64'(n_ferr - e0), 64'(1));
      chk("bad_wrs",  64'(n_wr - w0),   64'(0));
      chk("bad_rds",  64'(n_rd - r0),   64'(0));
      chk("bad_done", 64'(n_done - d0), 64'(0));
    end
    snap();
    wr_exp_q.push_back({16'h0050, 32'hDEADBEEF});
    csn_low();
    send_hdr(8'h02, 16'h0050, 8'h01);
    spi_xfer(32'hDEADBEEF, 32, rx);
    csn_high();
    chk("post_bad_left", 64'(wr_exp_q.size()), 64'(0));
    chk("post_bad_done", 64'(n_done - d0),     64'(1));

    // abort inside ADDR, then address wrap
    snap();
    csn_low();
    spi_xfer(32'h02, 8, rx);
    spi_xfer(32'h0ABC, 12, rx);
    csn_high();
    chk("abort_err", 64'(n_ferr - e0), 64'(1));
    chk("abort_wrs", 64'(n_wr - w0),   64'(0));
    snap();
    wr_exp_q.push_back({16'hFFFF, 32'h01020304});
    wr_exp_q.push_back({16'h0000, 32'h05060708});
    csn_low();
    send_hdr(8'h02, 16'hFFFF, 8'h02);
    spi_xfer(32'h01020304, 32, rx);
    spi_xfer(32'h05060708, 32, rx);
    csn_high();
    chk("wrap_left", 64'(wr_exp_q.size()), 64'(0));
    chk("wrap_done", 64'(n_done - d0),     64'(1));
    chk("wrap_err",  64'(n_ferr - e0),     64'(0));

    // reset pulse in the middle of word 1 of a four-word write
    snap();
    wr_exp_q.push_back({16'h0060, 32'h60606060});
    csn_low();
    send_hdr(8'h02, 16'h0060, 8'h04);
    spi_xfer(32'h60606060, 32, rx);
    spi_xfer(32'h0000BEEF, 16, rx);
    reset_n = 1'b0;
    wait_clk(1);
    chk("mid_rst_write",  64'(avmm_write),  64'(0));
    chk("mid_rst_addr",   64'(avmm_addr),   64'(0));
    chk("mid_rst_wrdata", 64'(avmm_wrdata), 64'(0));
    chk("mid_rst_miso",   64'(spis_miso),   64'(0));
    reset_n = 1'b1;
    spi_xfer(32'h00001111, 16, rx);
    spi_xfer(32'h22222222, 32, rx);
    spi_xfer(32'h33333333, 32, rx);
    csn_high();
    chk("mid_rst_wrs",  64'(n_wr - w0),   64'(1));
    chk("mid_rst_err",  64'(n_ferr - e0), 64'(0));
    chk("mid_rst_done", 64'(n_done - d0), 64'(0));
    snap();
    wr_exp_q.push_back({16'h0070, 32'h77777777});
    csn_low();
    send_hdr(8'h02, 16'h0070, 8'h01);
    spi_xfer(32'h77777777, 32, rx);
    csn_high();
    chk("post_rst_left", 64'(wr_exp_q.size()), 64'(0));
    chk("post_rst_done", 64'(n_done - d0),     64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
